// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the synchronous FIFO family.
//   - default geometry (FIFO_DEF_WL, FIFO_DEF_DEPTH)
//   - width helpers for pointer and occupancy counters
//   - fifo_op_e: per-cycle operation class used to update the occupancy count
package fifo_pkg;

  localparam int unsigned FIFO_DEF_WL    = 8;
  localparam int unsigned FIFO_DEF_DEPTH = 16;

  // Pointer width for a power-of-two depth (depth >= 2 gives at least 1 bit).
  function automatic int unsigned fifo_aw(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Occupancy counter width: one extra bit so that count == DEPTH is representable.
  function automatic int unsigned fifo_cw(input int unsigned depth);
    return fifo_aw(depth) + 1;
  endfunction

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage : fifo_pkg

// File: rtl/fifo_ram.sv
// fifo_ram: DEPTH x WL simple dual-port storage array.
// Ports:
//   i_clk   - rising-edge clock
//   i_we    - write enable (synchronous)
//   i_waddr - write address
//   i_wdata - write data
//   i_raddr - read address
//   o_rdata - read data (asynchronous)
// Contents are never reset.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int unsigned WL    = FIFO_DEF_WL,
  parameter int unsigned DEPTH = FIFO_DEF_DEPTH,
  parameter int unsigned AW    = fifo_aw(FIFO_DEF_DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [WL-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [WL-1:0] o_rdata
);

  logic [WL-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : fifo_ram

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO with first-word-fall-through
// head, registered pop data, occupancy count, almost flags and sticky errors.
// Ports:
//   CLK          - rising-edge clock
//   RST_N        - synchronous active-low reset
//   PUSH / POP   - write / read requests
//   CLR_ERR      - clears sticky OVF/UDF (a new error in the same cycle wins)
//   din          - write data
//   head         - oldest entry, 0 when EMPTY
//   dout         - word removed by the last accepted pop
//   count        - occupancy 0..DEPTH
//   EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL - decoded from registered count
//   OVF / UDF    - sticky rejected-push / rejected-pop flags
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter  int unsigned WL     = FIFO_DEF_WL,
  parameter  int unsigned DEPTH  = FIFO_DEF_DEPTH,
  parameter  int unsigned AF_LVL = DEPTH - 2,
  parameter  int unsigned AE_LVL = 2,
  localparam int unsigned A_WL   = fifo_aw(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          PUSH,
  input  logic          POP,
  input  logic          CLR_ERR,
  input  logic [WL-1:0] din,
  output logic [WL-1:0] head,
  output logic [WL-1:0] dout,
  output logic [A_WL:0] count,
  output logic          EMPTY,
  output logic          FULL,
  output logic          ALMOST_EMPTY,
  output logic          ALMOST_FULL,
  output logic          OVF,
  output logic          UDF
);

  logic [A_WL-1:0] r_wr_ptr;
  logic [A_WL-1:0] r_rd_ptr;
  logic [A_WL:0]   r_count;
  logic [WL-1:0]   r_dout;
  logic            r_ovf;
  logic            r_udf;

  logic [WL-1:0]   w_rdata;
  logic [31:0]     w_count32;
  logic            w_empty;
  logic            w_full;
  logic            w_pop_ok;
  logic            w_push_ok;
  logic            w_we;
  fifo_op_e        w_op;

  // ---------------------------------------------------------------------------
  // Flag decode from the registered count
  // ---------------------------------------------------------------------------
  assign w_count32 = 32'(r_count);
  assign w_empty   = (w_count32 == 32'd0);
  assign w_full    = (w_count32 == DEPTH);

  // A push while full is only accepted when a pop frees the slot in the same cycle.
  assign w_pop_ok  = POP && !w_empty;
  assign w_push_ok = PUSH && (!w_full || w_pop_ok);

  // Gating with RST_N keeps a push presented during reset out of the array.
  assign w_we      = w_push_ok && RST_N;

  always_comb begin
    w_op = OP_NONE;
    unique case ({w_pop_ok, w_push_ok})
      2'b01:   w_op = OP_PUSH;
      2'b10:   w_op = OP_POP;
      2'b11:   w_op = OP_BOTH;
      default: w_op = OP_NONE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  fifo_ram #(
    .WL    (WL),
    .DEPTH (DEPTH),
    .AW    (A_WL)
  ) u_ram (
    .i_clk   (CLK),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (din),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // ---------------------------------------------------------------------------
  // Pointers, count and popped data
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_dout   <= head;
      end
      unique case (w_op)
        OP_PUSH: r_count <= r_count + 1'b1;
        OP_POP:  r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags: a new error takes priority over CLR_ERR
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (PUSH && !w_push_ok) begin
        r_ovf <= 1'b1;
      end else if (CLR_ERR) begin
        r_ovf <= 1'b0;
      end
      if (POP && !w_pop_ok) begin
        r_udf <= 1'b1;
      end else if (CLR_ERR) begin
        r_udf <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Forcing 0 when empty also hides uninitialised array contents.
  assign head         = w_empty ? '0 : w_rdata;
  assign dout         = r_dout;
  assign count        = r_count;
  assign EMPTY        = w_empty;
  assign FULL         = w_full;
  assign ALMOST_EMPTY = (w_count32 <= AE_LVL);
  assign ALMOST_FULL  = (w_count32 >= AF_LVL);
  assign OVF          = r_ovf;
  assign UDF          = r_udf;

endmodule : fifo_sync_param

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Parametrised single-clock synchronous FIFO; next generation of the team's 4x4 SRL-based FIFO.
- Arbitrary width and power-of-two depth; circular-buffer RAM with read/write pointers.
- Adds occupancy count, programmable almost-full/almost-empty flags, push-while-full-with-pop, and sticky overflow/underflow error flags.
- Sits between producer and consumer datapaths in the same clock domain.

Parameters:
- WL, 8, data word width in bits (>=1).
- DEPTH, 16, number of entries; power of two, >=2.
- AF_LVL, DEPTH-2, ALMOST_FULL asserts when count >= AF_LVL.
- AE_LVL, 2, ALMOST_EMPTY asserts when count <= AE_LVL.
- A_WL, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  synchronous active-low reset.
- PUSH  in  1  write request.
- POP  in  1  read request.
- CLR_ERR  in  1  clears sticky OVF/UDF.
- din  in  WL  write data.
- head  out  WL  oldest entry, first-word-fall-through; 0 when EMPTY.
- dout  out  WL  registered popped word.
- count  out  A_WL+1  current occupancy, 0..DEPTH.
- EMPTY  out  1  count==0.
- FULL  out  1  count==DEPTH.
- ALMOST_EMPTY  out  1  count<=AE_LVL.
- ALMOST_FULL  out  1  count>=AF_LVL.
- OVF  out  1  sticky: push rejected.
- UDF  out  1  sticky: pop rejected.

Behaviour:
- Reset (RST_N=0 at posedge): wr_ptr=rd_ptr=0, count=0, dout=0, OVF=UDF=0. EMPTY=1, ALMOST_EMPTY=1, FULL=0, ALMOST_FULL=(AF_LVL==0). RAM contents are not cleared.
- Reset mid-operation discards all stored data; head shows 0 from the next cycle.
- pop_ok = POP && !EMPTY.
- push_ok = PUSH && (!FULL || pop_ok). A push while full is accepted only alongside a valid pop.
- Accepted push: mem[wr_ptr] <= din; wr_ptr increments modulo DEPTH, with natural wrap at A_WL bits.
- Accepted pop: dout <= head (the value before the edge); rd_ptr increments modulo DEPTH. dout holds its value otherwise.
- count_next = count + push_ok - pop_ok. Simultaneous push_ok and pop_ok leave count unchanged.
- Push into empty FIFO: head = that word from the next cycle (1-cycle write-to-head latency).
- Push and pop both requested while EMPTY: the pop is rejected, UDF sets, and the push is accepted.
- head is combinational from mem[rd_ptr], forced to 0 when EMPTY.
- All flags are derived combinationally from the registered count, so they are valid in the cycle after the causing edge.
- OVF sets when PUSH && !push_ok; UDF sets when POP && !pop_ok. Both clear only on reset or CLR_ERR.
- If CLR_ERR and a new error occur in the same cycle, the flag is set (set wins).
- No X is ever driven on any output.

Decomposition:
- Shared package fifo_pkg holds:
  - function clog2-based width helpers;
  - localparam defaults (FIFO_DEF_WL=8, FIFO_DEF_DEPTH=16).
- Sub-module fifo_ram: DEPTH x WL simple dual-port array, synchronous write (we, waddr, wdata), asynchronous read (raddr, rdata).
- Top-level holds pointers, count, flags and dout.

Test Plan:
- Reset, then push 0x11,0x22,0x33 on three cycles -> count=3, head=0x11, EMPTY=0; pop once -> dout=0x11, head=0x22, count=2.
- Fill 16 entries 0x00..0x0F (DEPTH=16) -> FULL=1 and ALMOST_FULL=1 from count=14; 17th push alone -> rejected, OVF=1, count=16; pulse CLR_ERR -> OVF=0.
- With FIFO full, assert PUSH=1,POP=1,din=0xAA -> dout=0x00, count stays 16, FULL=1; after draining, 0xAA is the last word out.
- Pop on empty -> UDF=1, dout unchanged, count=0. PUSH+POP together on empty with din=0x5A -> count=1, head=0x5A, UDF=1.
- Run 40 push/pop pairs with an incrementing pattern through DEPTH=16 (pointer wrap twice) -> output sequence equals input sequence, count never exceeds 16.
- Load 5 words, assert RST_N=0 for one cycle -> count=0, EMPTY=1, head=0, dout=0, OVF=UDF=0. A subsequent push of 0x77 -> head=0x77.
